// File: rtl/diffeq_pkg.sv
// -----------------------------------------------------------------------------
// diffeq_pkg
// Shared definitions for the differential-equation sequencer:
//   - default word width / fractional bits of the fixed-point format
//   - multiplier result tags (which product a returning result belongs to)
//   - FSM state encodings
// -----------------------------------------------------------------------------
package diffeq_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_FRAC  = 8;

  // Tags travel alongside each multiply so the sequencer knows which
  // product is coming back. Zero is left unused so a flushed pipe never
  // looks like a real tag.
  typedef logic [1:0] tag_t;
  localparam tag_t TAG_M1 = 2'd1;  // u * dx
  localparam tag_t TAG_M5 = 2'd2;  // y * dx
  localparam tag_t TAG_M3 = 2'd3;  // x * m1

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_CHECK   = 3'd1;
  localparam state_t ST_ISSUE_A = 3'd2;
  localparam state_t ST_ISSUE_B = 3'd3;
  localparam state_t ST_WAIT_M1 = 3'd4;
  localparam state_t ST_WAIT_M3 = 3'd5;
  localparam state_t ST_UPDATE  = 3'd6;
  localparam state_t ST_DONE    = 3'd7;

endpackage

// File: rtl/diffeq_mul_pipe.sv
// -----------------------------------------------------------------------------
// diffeq_mul_pipe
// Shared pipelined fixed-point multiplier. The full signed product is
// shifted right arithmetically by FRAC (floor) and truncated to WIDTH bits,
// then carried through MUL_LAT register stages together with its tag.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   in_valid, a, b, tag   operand issue (signed Q-format operands)
//   out_valid, product    result MUL_LAT cycles after issue
//   out_tag               tag that was issued with the operands
// -----------------------------------------------------------------------------
module diffeq_mul_pipe
  import diffeq_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int FRAC    = DEF_FRAC,
  parameter int MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       tag,
  output logic             out_valid,
  output logic [WIDTH-1:0] product,
  output logic [1:0]       out_tag
);

  logic signed [2*WIDTH-1:0] w_full;
  logic        [WIDTH-1:0]   w_trunc;

  logic             r_vld  [MUL_LAT];
  logic [WIDTH-1:0] r_prod [MUL_LAT];
  logic [1:0]       r_tag  [MUL_LAT];

  assign w_full  = $signed(a) * $signed(b);
  // Arithmetic shift gives floor rounding; the size cast drops the high bits.
  assign w_trunc = WIDTH'(w_full >>> FRAC);

  // Pipeline stages; reset flushes every valid bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MUL_LAT; i++) begin
        r_vld[i]  <= 1'b0;
        r_prod[i] <= '0;
        r_tag[i]  <= 2'd0;
      end
    end else begin
      r_vld[0]  <= in_valid;
      r_prod[0] <= w_trunc;
      r_tag[0]  <= tag;
      for (int i = 1; i < MUL_LAT; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_prod[i] <= r_prod[i-1];
        r_tag[i]  <= r_tag[i-1];
      end
    end
  end

  assign out_valid = r_vld[MUL_LAT-1];
  assign product   = r_prod[MUL_LAT-1];
  assign out_tag   = r_tag[MUL_LAT-1];

endmodule

// File: rtl/diffeq_sequencer.sv
// -----------------------------------------------------------------------------
// diffeq_sequencer
// Iterating controller for the loop
//   while (x < a) { u -= 3*x*u*dx + 3*y*dx; y += u*dx; x += dx; }
// Each iteration issues u*dx (M1), y*dx (M5) and x*m1 (M3) onto one shared
// pipelined multiplier on a fixed schedule of 2*MUL_LAT+2 cycles.
// Ports:
//   clk, reset                   clock, asynchronous active-high reset
//   start                        load operands and run (only in IDLE/DONE)
//   x_in,y_in,u_in,dx_in,a_in    initial operands, signed fixed point
//   busy                         run in progress
//   done                         one-cycle pulse on entering DONE
//   valid                        results stable (level)
//   limit_hit                    loop stopped on MAX_ITER, not on x >= a
//   x_out,y_out,u_out            current x/y/u registers
//   iter_count                   iterations completed
// -----------------------------------------------------------------------------
module diffeq_sequencer
  import diffeq_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int FRAC     = DEF_FRAC,
  parameter int MUL_LAT  = 2,
  parameter int MAX_ITER = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  input  logic [WIDTH-1:0] u_in,
  input  logic [WIDTH-1:0] dx_in,
  input  logic [WIDTH-1:0] a_in,
  output logic             busy,
  output logic             done,
  output logic             valid,
  output logic             limit_hit,
  output logic [WIDTH-1:0] x_out,
  output logic [WIDTH-1:0] y_out,
  output logic [WIDTH-1:0] u_out,
  output logic [7:0]       iter_count
);

  localparam logic [7:0] MAX_ITER_W = 8'(MAX_ITER);

  // 3*v built from a shift and an add so it stays off the multiplier.
  function automatic logic [WIDTH-1:0] times3(input logic [WIDTH-1:0] v);
    return {v[WIDTH-2:0], 1'b0} + v;
  endfunction

  state_t           r_state;
  logic [WIDTH-1:0] r_x, r_y, r_u, r_dx, r_a;
  logic [WIDTH-1:0] r_m1, r_m3, r_m5;
  logic [7:0]       r_iter;
  logic             r_busy, r_done, r_valid, r_limit;

  state_t           w_next_state;
  logic             w_mul_valid;
  logic [WIDTH-1:0] w_mul_a, w_mul_b;
  tag_t             w_mul_tag;
  logic             w_mul_out_valid;
  logic [WIDTH-1:0] w_mul_product;
  tag_t             w_mul_out_tag;

  logic             w_m1_hit, w_m3_hit, w_m5_hit;
  logic [WIDTH-1:0] w_x_new, w_y_new, w_u_new;
  logic [7:0]       w_iter_new;
  logic             w_x_lt_a, w_x_new_lt_a, w_continue;

  diffeq_mul_pipe #(
    .WIDTH   (WIDTH),
    .FRAC    (FRAC),
    .MUL_LAT (MUL_LAT)
  ) u_mul (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (w_mul_valid),
    .a         (w_mul_a),
    .b         (w_mul_b),
    .tag       (w_mul_tag),
    .out_valid (w_mul_out_valid),
    .product   (w_mul_product),
    .out_tag   (w_mul_out_tag)
  );

  assign w_m1_hit = w_mul_out_valid && (w_mul_out_tag == TAG_M1);
  assign w_m3_hit = w_mul_out_valid && (w_mul_out_tag == TAG_M3);
  assign w_m5_hit = w_mul_out_valid && (w_mul_out_tag == TAG_M5);

  // Adder path; all arithmetic wraps modulo 2^WIDTH.
  assign w_x_new      = r_x + r_dx;
  assign w_y_new      = r_y + r_m1;
  assign w_u_new      = r_u - times3(r_m3) - times3(r_m5);
  assign w_iter_new   = r_iter + 8'd1;
  assign w_x_lt_a     = $signed(r_x) < $signed(r_a);
  assign w_x_new_lt_a = $signed(w_x_new) < $signed(r_a);
  assign w_continue   = w_x_new_lt_a && (w_iter_new < MAX_ITER_W);

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) w_next_state = ST_CHECK;
        else       w_next_state = r_state;
      end
      ST_CHECK: begin
        if (w_x_lt_a) w_next_state = ST_ISSUE_A;
        else          w_next_state = ST_DONE;
      end
      ST_ISSUE_A: w_next_state = ST_ISSUE_B;
      ST_ISSUE_B: w_next_state = ST_WAIT_M1;
      ST_WAIT_M1: begin
        if (w_m1_hit) w_next_state = ST_WAIT_M3;
        else          w_next_state = ST_WAIT_M1;
      end
      ST_WAIT_M3: begin
        if (w_m3_hit) w_next_state = ST_UPDATE;
        else          w_next_state = ST_WAIT_M3;
      end
      ST_UPDATE: begin
        if (w_continue) w_next_state = ST_ISSUE_A;
        else            w_next_state = ST_DONE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Multiplier issue mux. M3 needs m1, so it is forwarded straight from
  // the multiplier output in the cycle the M1 result returns.
  always_comb begin
    w_mul_valid = 1'b0;
    w_mul_a     = '0;
    w_mul_b     = '0;
    w_mul_tag   = 2'd0;
    case (r_state)
      ST_ISSUE_A: begin
        w_mul_valid = 1'b1;
        w_mul_a     = r_u;
        w_mul_b     = r_dx;
        w_mul_tag   = TAG_M1;
      end
      ST_ISSUE_B: begin
        w_mul_valid = 1'b1;
        w_mul_a     = r_y;
        w_mul_b     = r_dx;
        w_mul_tag   = TAG_M5;
      end
      ST_WAIT_M1: begin
        if (w_m1_hit) begin
          w_mul_valid = 1'b1;
          w_mul_a     = r_x;
          w_mul_b     = w_mul_product;
          w_mul_tag   = TAG_M3;
        end else begin
          w_mul_valid = 1'b0;
        end
      end
      default: w_mul_valid = 1'b0;
    endcase
  end

  // State register and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= (w_next_state != ST_IDLE) && (w_next_state != ST_DONE);
      r_done  <= (w_next_state == ST_DONE) && (r_state != ST_DONE);
      // Valid holds while parked in DONE and drops once a new run starts.
      r_valid <= (w_next_state == ST_DONE);
    end
  end

  // Operand registers, product captures and iteration bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x     <= '0;
      r_y     <= '0;
      r_u     <= '0;
      r_dx    <= '0;
      r_a     <= '0;
      r_m1    <= '0;
      r_m3    <= '0;
      r_m5    <= '0;
      r_iter  <= 8'd0;
      r_limit <= 1'b0;
    end else begin
      if (w_m5_hit) r_m5 <= w_mul_product;
      if (w_m3_hit) r_m3 <= w_mul_product;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_x     <= x_in;
            r_y     <= y_in;
            r_u     <= u_in;
            r_dx    <= dx_in;
            r_a     <= a_in;
            r_iter  <= 8'd0;
            r_limit <= 1'b0;
          end
        end
        ST_WAIT_M1: begin
          if (w_m1_hit) r_m1 <= w_mul_product;
        end
        ST_UPDATE: begin
          r_x    <= w_x_new;
          r_y    <= w_y_new;
          r_u    <= w_u_new;
          r_iter <= w_iter_new;
          if (!w_continue) r_limit <= w_x_new_lt_a;
        end
        default: r_iter <= r_iter;
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign valid      = r_valid;
  assign limit_hit  = r_limit;
  assign x_out      = r_x;
  assign y_out      = r_y;
  assign u_out      = r_u;
  assign iter_count = r_iter;

endmodule
